// File: rtl/sub_mod_8_parts.sv
// rtl/sub_mod_8_parts.sv - staged modular subtractor, (a - b) mod p one chunk per cycle
// Subtracts chunk-by-chunk with a registered borrow; on a final borrow adds p back the same way.
module sub_mod_8_parts #(
  parameter int SIZE  = 448,
  parameter int PARTS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic [SIZE-1:0] p,
  output logic [SIZE-1:0] result,
  output logic            done
);

  localparam int W  = SIZE / PARTS;
  localparam int IW = (PARTS > 1) ? $clog2(PARTS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SUB  = 2'd1;
  localparam logic [1:0] ADD  = 2'd2;

  logic [1:0]      state;
  logic [IW-1:0]   idx;
  logic [SIZE-1:0] a_r;
  logic [SIZE-1:0] b_r;
  logic [SIZE-1:0] p_r;
  logic [SIZE-1:0] diff;
  logic            borrow;
  logic            carry;

  logic [W:0]      sub_full;
  logic [W:0]      add_full;
  logic [SIZE-1:0] diff_next;
  logic            last;

  // One W-bit slice per cycle; the extra top bit is the borrow/carry out.
  always_comb begin
    sub_full  = {1'b0, a_r[idx*W +: W]} - {1'b0, b_r[idx*W +: W]} - {{W{1'b0}}, borrow};
    add_full  = {1'b0, diff[idx*W +: W]} + {1'b0, p_r[idx*W +: W]} + {{W{1'b0}}, carry};
    diff_next = diff;
    if (state == ADD) begin
      diff_next[idx*W +: W] = add_full[W-1:0];
    end else begin
      diff_next[idx*W +: W] = sub_full[W-1:0];
    end
    last = (idx == IW'(PARTS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      p_r    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
      carry  <= 1'b0;
      result <= '0;
      done   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r    <= a;
            b_r    <= b;
            p_r    <= p;
            idx    <= '0;
            borrow <= 1'b0;
            carry  <= 1'b0;
            done   <= 1'b0;
            state  <= SUB;
          end
        end
        SUB: begin
          diff   <= diff_next;
          borrow <= sub_full[W];
          if (!last) begin
            idx <= idx + 1'b1;
          end else if (!sub_full[W]) begin
            result <= diff_next;
            done   <= 1'b1;
            state  <= IDLE;
          end else begin
            idx   <= '0;
            carry <= 1'b0;
            state <= ADD;
          end
        end
        ADD: begin
          // The final carry-out is the 2^SIZE wrap and is intentionally dropped.
          diff  <= diff_next;
          carry <= add_full[W];
          if (!last) begin
            idx <= idx + 1'b1;
          end else begin
            result <= diff_next;
            done   <= 1'b1;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_mod_8_parts.sv
// tb/tb_sub_mod_8_parts.sv - directed and randomized checks of sub_mod_8_parts
module tb_sub_mod_8_parts;

  localparam int SIZE  = 448;
  localparam int PARTS = 8;
  localparam int W     = SIZE / PARTS;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic [SIZE-1:0] p;
  logic [SIZE-1:0] result;
  logic            done;

  int n_cmp;
  int n_err;

  sub_mod_8_parts #(.SIZE(SIZE), .PARTS(PARTS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .p      (p),
    .result (result),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [SIZE-1:0] model(input logic [SIZE-1:0] ma, mb, mp);
    if (ma >= mb) return ma - mb;
    return ma - mb + mp;
  endfunction

  function automatic logic [SIZE-1:0] rnd448();
    logic [SIZE-1:0] r;
    r = '0;
    for (int i = 0; i < SIZE / 32; i++) r = {r[SIZE-33:0], 32'($urandom)};
    return r;
  endfunction

  task automatic check(input string tag, input logic [SIZE-1:0] obs, input logic [SIZE-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) return;
    end
    lat = 99;
  endtask

  task automatic do_op(input logic [SIZE-1:0] ta, tb, tp, input int lat_exp, input string tag);
    int lat;
    logic [SIZE-1:0] exp;
    exp = model(ta, tb, tp);
    @(negedge clk);
    a = ta; b = tb; p = tp; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_busy"}, SIZE'(done), SIZE'(0));
    wait_done(lat);
    check({tag, "_lat"}, SIZE'(lat), SIZE'(lat_exp));
    check({tag, "_res"}, result, exp);
  endtask

  logic [SIZE-1:0] p25519;
  logic [SIZE-1:0] one;
  logic [SIZE-1:0] ra, rb, rp, na, nb, np, rexp;
  int lat;

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; p = '0;
    one = 1;
    p25519 = (one << 255) - 19;

    // reset and idle behaviour
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", SIZE'(done), SIZE'(1));
    check("rst_res", result, '0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_done", SIZE'(done), SIZE'(1));
    check("idle_res", result, '0);

    // directed cases
    do_op(10, 3, p25519, 8, "a10b3");
    do_op(3, 10, p25519, 16, "a3b10");
    check("a3b10_pm7", result, p25519 - 7);
    do_op(SIZE'('h1234), SIZE'('h1234), p25519, 8, "eq1234");
    do_op('0, '0, p25519, 8, "zeros");
    do_op(one << (7 * W), one, p25519, 8, "ripple_borrow");
    check("ripple_val", result, (one << (7 * W)) - 1);
    do_op('0, p25519 - 1, p25519, 16, "ripple_carry");
    check("ripple_carry_1", result, one);

    // restart while busy is ignored and inputs are latched
    @(negedge clk);
    a = 100; b = 40; p = p25519; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = 5; b = 77;
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat);
    check("restart_lat", SIZE'(lat + 3), SIZE'(8));
    check("restart_res", result, SIZE'(60));
    repeat (2) @(posedge clk);
    #1;
    check("restart_idle", SIZE'(done), SIZE'(1));

    // asynchronous reset mid-operation
    @(negedge clk);
    a = 3; b = 10; p = p25519; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_done", SIZE'(done), SIZE'(1));
    check("abort_res", result, '0);
    @(negedge clk) rst_n = 1'b1;
    do_op(50, 80, p25519, 16, "after_abort");

    // random ops with start held high
    rp = rnd448() | (one << (SIZE - 1));
    ra = rnd448() % rp;
    rb = rnd448() % rp;
    @(negedge clk);
    a = ra; b = rb; p = rp; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 24; k++) begin
      #1;
      check("rnd_busy", SIZE'(done), SIZE'(0));
      rexp = model(ra, rb, rp);
      np = rnd448() | (one << (SIZE - 1));
      if (k % 4 == 0) np = p25519;
      na = rnd448() % np;
      nb = rnd448() % np;
      if (k % 3 == 0) begin
        na = nb; nb = na + (np - na) / 2;  // forces a < b
        if (na == nb) nb = (na + 1) % np;
      end
      a = 'x; b = 'x;
      wait_done(lat);
      check("rnd_lat", SIZE'(lat), SIZE'((ra >= rb) ? 8 : 16));
      check("rnd_res", result, rexp);
      ra = na; rb = nb; rp = np;
      a = ra; b = rb; p = rp;
      @(posedge clk);
    end
    #1 start = 1'b0;
    wait_done(lat);
    check("rnd_tail", result, model(ra, rb, rp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
